// File: rtl/load_wb_queue.sv
// Load/store writeback stage: counts outstanding memory requests, buffers responses in a FIFO,
// aligns load data and retires instructions in order, with flush-driven discard of in-flight replies.
module load_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  input  logic        stall_in,
  output logic        stall_out,
  output logic        valid_out,
  input  logic        flush,
  input  logic        req_fire,
  output logic        req_ready,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  ld_op,
  input  logic [31:0] result_in,
  input  logic [31:0] rdata2_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  output logic        wb,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        resp_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [CNT_W-1:0] total_out_q, total_out_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic             resp_err_q, resp_err_d;

  logic        needs_data, fifo_empty, resp_ok, push, pop;
  logic [31:0] head;
  logic [4:0]  rsh, lsh;
  logic [31:0] d_shr, d_shl;

  assign needs_data = mem_r | mem_w;
  assign fifo_empty = (fifo_count_q == '0);
  // A response only counts when something is actually outstanding.
  assign resp_ok    = data_data_ok && (total_out_q != '0);
  assign push       = resp_ok && (discard_cnt_q == '0) && !flush;
  assign pop        = valid_in && needs_data && !fifo_empty && !stall_in && !flush;

  assign stall_out = valid_in & ((needs_data & fifo_empty) | stall_in);
  assign valid_out = valid_in & !stall_out & !flush;
  assign wb        = valid_in & wb_en_in;
  assign wb_valid  = wb & !stall_out & !flush;
  assign wb_addr   = (valid_in && wb_en_in) ? wb_addr_in : 5'd0;
  assign resp_err  = resp_err_q;
  assign req_ready = ({1'b0, total_out_q} + {1'b0, fifo_count_q}) < (CNT_W+1)'(DEPTH);

  always_comb begin
    total_out_d = total_out_q;
    case ({req_fire, resp_ok})
      2'b10:   total_out_d = total_out_q + CNT_W'(1);
      2'b01:   total_out_d = total_out_q - CNT_W'(1);
      default: total_out_d = total_out_q;
    endcase

    resp_err_d = resp_err_q | (data_data_ok && (total_out_q == '0));

    // On flush every request still in flight, including this cycle's, must be discarded.
    discard_cnt_d = discard_cnt_q;
    if (flush)
      discard_cnt_d = total_out_d;
    else if (resp_ok && (discard_cnt_q != '0))
      discard_cnt_d = discard_cnt_q - CNT_W'(1);

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign rsh   = {result_in[1:0], 3'b000};
  assign lsh   = {~result_in[1:0], 3'b000};
  assign d_shr = head >> rsh;
  assign d_shl = head << lsh;

  always_comb begin
    wb_data = result_in;
    if (mem_r) begin
      case (ld_op)
        3'd1:    wb_data = {{24{d_shr[7]}}, d_shr[7:0]};
        3'd2:    wb_data = {24'd0, d_shr[7:0]};
        3'd3:    wb_data = {{16{d_shr[15]}}, d_shr[15:0]};
        3'd4:    wb_data = {16'd0, d_shr[15:0]};
        3'd5:    wb_data = d_shl | (rdata2_in & ~(32'hFFFF_FFFF << lsh));
        3'd6:    wb_data = d_shr | (rdata2_in & ~(32'hFFFF_FFFF >> rsh));
        default: wb_data = head;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_count_q  <= '0;
      total_out_q   <= '0;
      discard_cnt_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_count_q  <= fifo_count_d;
      total_out_q   <= total_out_d;
      discard_cnt_q <= discard_cnt_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_wb_queue.sv
// Directed self-checking bench for load_wb_queue: inputs change 1ns after a rising edge,
// outputs are compared 1ns later, well before the next edge.
module tb_load_wb_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_in, stall_in, flush, req_fire;
  logic        stall_out, valid_out, req_ready;
  logic [31:0] data_rdata;
  logic        data_data_ok, mem_r, mem_w;
  logic [2:0]  ld_op;
  logic [31:0] result_in, rdata2_in;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic        wb, wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        resp_err;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] burstData [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

  load_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .valid_in(valid_in), .stall_in(stall_in),
    .stall_out(stall_out), .valid_out(valid_out), .flush(flush), .req_fire(req_fire),
    .req_ready(req_ready), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_r(mem_r), .mem_w(mem_w), .ld_op(ld_op), .result_in(result_in),
    .rdata2_in(rdata2_in), .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in),
    .wb(wb), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .resp_err(resp_err)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic w, input logic [2:0] op,
                               input logic [31:0] res, input logic [31:0] rd2);
    valid_in  = v;
    mem_r     = r;
    mem_w     = w;
    ld_op     = op;
    result_in = res;
    rdata2_in = rd2;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] dat);
    data_data_ok = 1'b1;
    data_rdata   = dat;
    cycle();
    data_data_ok = 1'b0;
  endtask

  task automatic fireReq();
    req_fire = 1'b1;
    cycle();
    req_fire = 1'b0;
  endtask

  // Whole directed sequence: reset, burst, alignment, empty-FIFO stall, flush, store, errors.
  initial begin
    resetn = 1'b0; stall_in = 1'b0; flush = 1'b0; req_fire = 1'b0;
    data_rdata = '0; data_data_ok = 1'b0; wb_en_in = 1'b0; wb_addr_in = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_stall_out", stall_out, 0);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_wb", wb, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_addr", wb_addr, 0);

    for (int i = 0; i < 4; i++) begin
      req_fire = 1'b1;
      cycle();
      if (i == 2) checkOutput("burst_ready_3out", req_ready, 1);
    end
    req_fire = 1'b0;
    #1 checkOutput("burst_ready_full", req_ready, 0);
    for (int i = 0; i < 4; i++) respond(burstData[i]);
    #1 checkOutput("burst_ready_buffered", req_ready, 0);
    checkOutput("burst_resp_err", resp_err, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h100, 32'd0);
    wb_en_in = 1'b1; wb_addr_in = 5'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("burst_stall_out", stall_out, 0);
      checkOutput("burst_wb_valid", wb_valid, 1);
      checkOutput("burst_valid_out", valid_out, 1);
      checkOutput("burst_wb_data", wb_data, burstData[i]);
      checkOutput("burst_wb_addr", wb_addr, 7);
      cycle();
      checkOutput("burst_ready_after_pop", req_ready, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("idle_wb_addr", wb_addr, 0);
    checkOutput("idle_wb", wb, 0);
    wb_en_in = 1'b0;

    fireReq();
    respond(32'h80FF_0000);
    stall_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'h3, 32'd0);
    #1 checkOutput("lb_off3", wb_data, 32'hFFFF_FF80);
    checkOutput("stalled_stall_out", stall_out, 1);
    checkOutput("stalled_wb_valid", wb_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'h3, 32'd0);
    #1 checkOutput("lbu_off3", wb_data, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h2, 32'd0);
    #1 checkOutput("lh_off2", wb_data, 32'hFFFF_80FF);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 32'h2, 32'd0);
    #1 checkOutput("lhu_off2", wb_data, 32'h0000_80FF);
    stall_in = 1'b0;
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    fireReq();
    respond(32'h1122_3344);
    stall_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'h1, 32'hAABB_CCDD);
    #1 checkOutput("lwl_off1", wb_data, 32'h3344_CCDD);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 32'h1, 32'hAABB_CCDD);
    #1 checkOutput("lwr_off1", wb_data, 32'hAA11_2233);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 32'h1, 32'hAABB_CCDD);
    #1 checkOutput("op7_word", wb_data, 32'h1122_3344);
    stall_in = 1'b0;
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    fireReq();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("wait_stall_out", stall_out, 1);
    checkOutput("wait_wb_valid", wb_valid, 0);
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_BABE;
    #1 checkOutput("wait_no_bypass", stall_out, 1);
    cycle();
    data_data_ok = 1'b0;
    checkOutput("wait_retire_stall", stall_out, 0);
    checkOutput("wait_retire_data", wb_data, 32'hCAFE_BABE);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    req_fire = 1'b1;
    repeat (2) cycle();
    req_fire = 1'b0;
    flush = 1'b1; wb_en_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("flush_valid_out", valid_out, 0);
    checkOutput("flush_wb_valid", wb_valid, 0);
    checkOutput("flush_wb", wb, 1);
    cycle();
    flush = 1'b0; wb_en_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    respond(32'hDEAD_BEEF);
    respond(32'hDEAD_BEEF);
    #1 checkOutput("flush_resp_err", resp_err, 0);
    checkOutput("flush_req_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("flush_dropped_stall", stall_out, 1);
    fireReq();
    respond(32'h5A5A_5A5A);
    checkOutput("post_flush_stall", stall_out, 0);
    checkOutput("post_flush_data", wb_data, 32'h5A5A_5A5A);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    fireReq();
    respond(32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h1234, 32'd0);
    #1 checkOutput("store_stall_out", stall_out, 0);
    checkOutput("store_wb_data", wb_data, 32'h1234);
    checkOutput("store_valid_out", valid_out, 1);
    cycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h1234, 32'd0);
    #1 checkOutput("store_consumed", stall_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    respond(32'h7777_7777);
    checkOutput("unexp_resp_err", resp_err, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("unexp_no_push", stall_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) cycle();
    checkOutput("unexp_sticky", resp_err, 1);

    fireReq();
    respond(32'h9999_9999);
    fireReq();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    #1 checkOutput("midrst_resp_err", resp_err, 0);
    checkOutput("midrst_req_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 checkOutput("midrst_fifo_empty", stall_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    respond(32'h1);
    checkOutput("midrst_total_cleared", resp_err, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
